// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-subset controller: state
// encoding, instruction field constants and datapath select encodings.
package ctrl_pkg;

    // Controller states; FETCH is the reset state.
    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_R_EXEC    = 4'd6,
        ST_R_WB      = 4'd7,
        ST_I_EXEC    = 4'd8,
        ST_I_WB      = 4'd9,
        ST_BRANCH    = 4'd10,
        ST_JUMP      = 4'd11,
        ST_JR        = 4'd12,
        ST_JAL       = 4'd13,
        ST_ILLEGAL   = 4'd14
    } state_e;

    // Opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes, instr[5:0]
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    // ALU commands
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;

    // Register-file destination select
    localparam logic [1:0] DST_RD = 2'b00;
    localparam logic [1:0] DST_RT = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] SRCB_FOUR    = 2'b00;
    localparam logic [1:0] SRCB_B       = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_A      = 2'b11;

    // Register write-data select
    localparam logic [1:0] DW_ALUOUT = 2'b00;
    localparam logic [1:0] DW_MEM    = 2'b01;
    localparam logic [1:0] DW_PC     = 2'b10;

    // All state-decoded controls in one bundle so a state's defaults are a
    // single '0 assignment.
    typedef struct packed {
        logic       ir_we;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_cmd;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_we;
        logic [1:0] dw_sel;
    } ctrl_out_t;

    // ALU command for an I-type arithmetic opcode.
    function automatic logic [2:0] imm_alu_cmd(input logic [5:0] opcode);
        return (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: instruction fields and ALU flag in,
// state-decoded datapath controls out.
interface multicycle_control_if;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;

    logic       ir_we;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_cmd;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_we;
    logic [1:0] dw_sel;
    logic       illegal;

    // Controller side
    modport master (
        input  opcode, funct, zero,
        output ir_we, reg_we, reg_dst, alu_src_a, alu_src_b, alu_cmd,
               pc_we, pc_src, iord, mem_we, dw_sel, illegal
    );

    // Datapath side
    modport slave (
        output opcode, funct, zero,
        input  ir_we, reg_we, reg_dst, alu_src_a, alu_src_b, alu_cmd,
               pc_we, pc_src, iord, mem_we, dw_sel, illegal
    );

endinterface

// File: rtl/multicycle_control_alu_cmd_decode.sv
// R-type funct to ALU command mapping; also flags which functs are
// supported arithmetic operations.
module alu_cmd_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] alu_cmd_o,
    output logic       arith_o
);

    // Map supported arithmetic functs; anything else reads as ADD, not arith.
    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latch.
        alu_cmd_o = ALU_ADD;
        arith_o   = 1'b0;
        case (funct_i)
            FN_ADD: begin alu_cmd_o = ALU_ADD; arith_o = 1'b1; end
            FN_SUB: begin alu_cmd_o = ALU_SUB; arith_o = 1'b1; end
            FN_SLT: begin alu_cmd_o = ALU_SLT; arith_o = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset controller: Moore FSM driving a shared-memory
// datapath (FETCH, DECODE, then per-class execute/write-back states).
// Optional build macro CTRL_ILLEGAL_TRAP_EN: when defined, ILLEGAL is a
// terminal state left only by reset; otherwise it is a one-cycle NOP that
// sets the sticky illegal flag.
module multicycle_control
    import ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    multicycle_control_if.master  bus
);

    state_e     state_q, state_d;
    logic [2:0] exec_cmd_q, exec_cmd_d;
    logic       illegal_q, illegal_d;

    logic [2:0] funct_cmd;
    logic       funct_arith;
    ctrl_out_t  ctl;

    alu_cmd_decode u_alu_cmd_decode (
        .funct_i   (bus.funct),
        .alu_cmd_o (funct_cmd),
        .arith_o   (funct_arith)
    );

    // Next-state logic; opcode/funct are only looked at in DECODE and MEM_ADDR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW:     state_d = ST_MEM_ADDR;
                    OP_RTYPE: begin
                        if (funct_arith)             state_d = ST_R_EXEC;
                        else if (bus.funct == FN_JR) state_d = ST_JR;
                        else                         state_d = ST_ILLEGAL;
                    end
                    OP_ADDI, OP_XORI: state_d = ST_I_EXEC;
                    OP_BNE:           state_d = ST_BRANCH;
                    OP_J:             state_d = ST_JUMP;
                    OP_JAL:           state_d = ST_JAL;
                    default:          state_d = ST_ILLEGAL;
                endcase
            end
            ST_MEM_ADDR: state_d = (bus.opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
            ST_MEM_READ: state_d = ST_MEM_WB;
            ST_R_EXEC:   state_d = ST_R_WB;
            ST_I_EXEC:   state_d = ST_I_WB;
            ST_MEM_WB, ST_MEM_WRITE, ST_R_WB, ST_I_WB,
            ST_BRANCH, ST_JUMP, ST_JR, ST_JAL:
                         state_d = ST_FETCH;
            ST_ILLEGAL: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                state_d = ST_ILLEGAL;
`else
                state_d = ST_FETCH;
`endif
            end
            default:     state_d = ST_FETCH;
        endcase
    end

    // Latch the execute-stage ALU command in DECODE so the execute states stay
    // Moore outputs even though the instruction fields are not re-sampled.
    always_comb begin
        exec_cmd_d = exec_cmd_q;
        if (state_q == ST_DECODE) begin
            exec_cmd_d = (bus.opcode == OP_RTYPE) ? funct_cmd : imm_alu_cmd(bus.opcode);
        end
    end

    // Sticky illegal flag, set on entry to ILLEGAL and cleared only by reset.
    always_comb begin
        illegal_d = illegal_q | (state_d == ST_ILLEGAL);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all state so every register
        // samples the pre-edge value of its inputs.
        if (!reset_n) begin
            state_q    <= ST_FETCH;
            exec_cmd_q <= ALU_ADD;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            exec_cmd_q <= exec_cmd_d;
            illegal_q  <= illegal_d;
        end
    end

    // State decode of the datapath controls; only BRANCH looks at an input.
    always_comb begin
        ctl = '0;
        case (state_q)
            ST_FETCH: begin
                ctl.ir_we     = 1'b1;
                ctl.pc_we     = 1'b1;
                ctl.iord      = 1'b0;
                ctl.alu_src_a = 1'b0;
                ctl.alu_src_b = SRCB_FOUR;
                ctl.alu_cmd   = ALU_ADD;
                ctl.pc_src    = PCSRC_ALU;
            end
            ST_DECODE: begin
                // Branch target precomputed into ALUOut.
                ctl.alu_src_a = 1'b0;
                ctl.alu_src_b = SRCB_IMM_SH2;
                ctl.alu_cmd   = ALU_ADD;
            end
            ST_MEM_ADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_cmd   = ALU_ADD;
            end
            ST_MEM_READ: begin
                ctl.iord = 1'b1;
            end
            ST_MEM_WB: begin
                ctl.reg_we  = 1'b1;
                ctl.reg_dst = DST_RT;
                ctl.dw_sel  = DW_MEM;
            end
            ST_MEM_WRITE: begin
                ctl.iord   = 1'b1;
                ctl.mem_we = 1'b1;
            end
            ST_R_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_B;
                ctl.alu_cmd   = exec_cmd_q;
            end
            ST_R_WB: begin
                ctl.reg_we  = 1'b1;
                ctl.reg_dst = DST_RD;
                ctl.dw_sel  = DW_ALUOUT;
            end
            ST_I_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_cmd   = exec_cmd_q;
            end
            ST_I_WB: begin
                ctl.reg_we  = 1'b1;
                ctl.reg_dst = DST_RT;
                ctl.dw_sel  = DW_ALUOUT;
            end
            ST_BRANCH: begin
                // BNE: take the ALUOut target when A != B.
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_B;
                ctl.alu_cmd   = ALU_SUB;
                ctl.pc_src    = PCSRC_ALUOUT;
                ctl.pc_we     = ~bus.zero;
            end
            ST_JUMP: begin
                ctl.pc_we  = 1'b1;
                ctl.pc_src = PCSRC_JUMP;
            end
            ST_JR: begin
                ctl.pc_we  = 1'b1;
                ctl.pc_src = PCSRC_A;
            end
            ST_JAL: begin
                // Link write sees the PC before this cycle's update.
                ctl.pc_we   = 1'b1;
                ctl.pc_src  = PCSRC_JUMP;
                ctl.reg_we  = 1'b1;
                ctl.reg_dst = DST_RA;
                ctl.dw_sel  = DW_PC;
            end
            default: ;
        endcase
    end

    // Drive the bundle; write enables are forced low while reset is held.
    always_comb begin
        bus.ir_we     = ctl.ir_we  & reset_n;
        bus.reg_we    = ctl.reg_we & reset_n;
        bus.pc_we     = ctl.pc_we  & reset_n;
        bus.mem_we    = ctl.mem_we & reset_n;
        bus.reg_dst   = ctl.reg_dst;
        bus.alu_src_a = ctl.alu_src_a;
        bus.alu_src_b = ctl.alu_src_b;
        bus.alu_cmd   = ctl.alu_cmd;
        bus.pc_src    = ctl.pc_src;
        bus.iord      = ctl.iord;
        bus.dw_sel    = ctl.dw_sel;
        bus.illegal   = illegal_q;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: table of instructions, a
// state/control scoreboard, and hand sequences for reset and ILLEGAL.
// Honours CTRL_ILLEGAL_TRAP_EN to pick the matching ILLEGAL expectations.
`timescale 1ns/1ps
module tb_multicycle_control;
    import ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset_n;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ir_we;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_cmd;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_we;
        logic [1:0] dw_sel;
        logic       illegal;
    } ctl_t;

    typedef struct {
        state_e st;
        ctl_t   ctl;
    } exp_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic [2:0] cmd;    // expected alu_cmd in the execute state
    } vec_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];
    vec_t vecs[$];
    logic model_illegal = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else             n_pass++;
    endtask

    function automatic ctl_t sample_ctl();
        ctl_t c;
        c.ir_we     = bus.ir_we;
        c.reg_we    = bus.reg_we;
        c.reg_dst   = bus.reg_dst;
        c.alu_src_a = bus.alu_src_a;
        c.alu_src_b = bus.alu_src_b;
        c.alu_cmd   = bus.alu_cmd;
        c.pc_we     = bus.pc_we;
        c.pc_src    = bus.pc_src;
        c.iord      = bus.iord;
        c.mem_we    = bus.mem_we;
        c.dw_sel    = bus.dw_sel;
        c.illegal   = bus.illegal;
        return c;
    endfunction

    // Expected controls per state, written from the control table.
    function automatic ctl_t exp_ctl(input state_e s, input logic [2:0] cmd,
                                     input logic zero, input logic ill);
        ctl_t c = '0;
        c.illegal = ill;
        case (s)
            ST_FETCH:     begin c.ir_we = 1; c.pc_we = 1; end
            ST_DECODE:    begin c.alu_src_b = 2'b11; end
            ST_MEM_ADDR:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            ST_MEM_READ:  begin c.iord = 1; end
            ST_MEM_WB:    begin c.reg_we = 1; c.reg_dst = 2'b01; c.dw_sel = 2'b01; end
            ST_MEM_WRITE: begin c.iord = 1; c.mem_we = 1; end
            ST_R_EXEC:    begin c.alu_src_a = 1; c.alu_src_b = 2'b01; c.alu_cmd = cmd; end
            ST_R_WB:      begin c.reg_we = 1; end
            ST_I_EXEC:    begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_cmd = cmd; end
            ST_I_WB:      begin c.reg_we = 1; c.reg_dst = 2'b01; end
            ST_BRANCH:    begin c.alu_src_a = 1; c.alu_src_b = 2'b01; c.alu_cmd = 3'b001;
                                c.pc_src = 2'b01; c.pc_we = ~zero; end
            ST_JUMP:      begin c.pc_we = 1; c.pc_src = 2'b10; end
            ST_JR:        begin c.pc_we = 1; c.pc_src = 2'b11; end
            ST_JAL:       begin c.pc_we = 1; c.pc_src = 2'b10; c.reg_we = 1;
                                c.reg_dst = 2'b10; c.dw_sel = 2'b10; end
            default: ;
        endcase
        return c;
    endfunction

    // Push the expected per-cycle state/controls of one instruction.
    task automatic push_instr(input vec_t v);
        state_e s[$];
        exp_t   e;
        s.push_back(ST_FETCH);
        s.push_back(ST_DECODE);
        case (v.op)
            6'b100011: begin s.push_back(ST_MEM_ADDR); s.push_back(ST_MEM_READ); s.push_back(ST_MEM_WB); end
            6'b101011: begin s.push_back(ST_MEM_ADDR); s.push_back(ST_MEM_WRITE); end
            6'b000000: begin
                if (v.funct == 6'b100000 || v.funct == 6'b100010 || v.funct == 6'b101010) begin
                    s.push_back(ST_R_EXEC); s.push_back(ST_R_WB);
                end else if (v.funct == 6'b001000) s.push_back(ST_JR);
                else                               s.push_back(ST_ILLEGAL);
            end
            6'b001000, 6'b001110: begin s.push_back(ST_I_EXEC); s.push_back(ST_I_WB); end
            6'b000101: s.push_back(ST_BRANCH);
            6'b000010: s.push_back(ST_JUMP);
            6'b000011: s.push_back(ST_JAL);
            default:   s.push_back(ST_ILLEGAL);
        endcase
        foreach (s[i]) begin
            if (s[i] == ST_ILLEGAL) model_illegal = 1'b1;
            e.st  = s[i];
            e.ctl = exp_ctl(s[i], v.cmd, v.zero, model_illegal);
            sb.push_back(e);
        end
    endtask

    // Compare the DUT against the next scoreboard entry.
    task automatic step_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({name, "_state"}, 32'(dut.state_q), 32'(e.st));
            check({name, "_ctl"},   32'(sample_ctl()), 32'(e.ctl));
        end
    endtask

    // Run one instruction from a FETCH negedge to the next FETCH negedge.
    task automatic run_instr(input vec_t v);
        int n;
        bus.opcode = v.op;
        bus.funct  = v.funct;
        bus.zero   = v.zero;
        push_instr(v);
        n = sb.size();
        for (int c = 0; c < n; c++) begin
            #1;
            step_check($sformatf("%s_c%0d", v.name, c + 1));
            @(negedge clk);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [5:0] op,
                                input logic [5:0] funct, input logic zero, input logic [2:0] cmd);
        vec_t v;
        v.name = name; v.op = op; v.funct = funct; v.zero = zero; v.cmd = cmd;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vecs.push_back(mk("lw",      6'b100011, 6'b000000, 1'b0, 3'b000));
        vecs.push_back(mk("sw",      6'b101011, 6'b000000, 1'b0, 3'b000));
        vecs.push_back(mk("add",     6'b000000, 6'b100000, 1'b0, 3'b000));
        vecs.push_back(mk("sub",     6'b000000, 6'b100010, 1'b0, 3'b001));
        vecs.push_back(mk("slt",     6'b000000, 6'b101010, 1'b0, 3'b011));
        vecs.push_back(mk("jr",      6'b000000, 6'b001000, 1'b0, 3'b000));
        vecs.push_back(mk("addi",    6'b001000, 6'b000000, 1'b0, 3'b000));
        vecs.push_back(mk("xori",    6'b001110, 6'b101010, 1'b0, 3'b010));
        vecs.push_back(mk("bne_tk",  6'b000101, 6'b000000, 1'b0, 3'b000));
        vecs.push_back(mk("bne_nt",  6'b000101, 6'b000000, 1'b1, 3'b000));
        vecs.push_back(mk("j",       6'b000010, 6'b000000, 1'b0, 3'b000));
        vecs.push_back(mk("jal",     6'b000011, 6'b000000, 1'b0, 3'b000));

        // Reset: enables held low even though the state decodes as FETCH.
        reset_n    = 1'b0;
        bus.opcode = 6'b000000;
        bus.funct  = 6'b000000;
        bus.zero   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", 32'(dut.state_q), 32'(ST_FETCH));
        check("rst_ctl",   32'(sample_ctl()), 32'd0);
        reset_n = 1'b1;

        // Table: LW first, immediately after reset release.
        foreach (vecs[i]) run_instr(vecs[i]);

        // Reset asserted in MEM_WRITE.
        bus.opcode = 6'b101011;
        repeat (3) @(negedge clk);
        #1;
        check("swrst_state_pre", 32'(dut.state_q), 32'(ST_MEM_WRITE));
        check("swrst_mem_we_pre", 32'(bus.mem_we), 32'd1);
        reset_n = 1'b0;
        #1;
        check("swrst_mem_we_same_cycle", 32'(bus.mem_we), 32'd0);
        @(posedge clk);
        #1;
        check("swrst_state_post", 32'(dut.state_q), 32'(ST_FETCH));
        @(negedge clk);
        reset_n = 1'b1;
        run_instr(mk("post_rst_add", 6'b000000, 6'b100000, 1'b0, 3'b000));

        // Illegal opcode 111111.
        run_instr(mk("ill", 6'b111111, 6'b000000, 1'b0, 3'b000));
`ifdef CTRL_ILLEGAL_TRAP_EN
        for (int c = 0; c < 10; c++) begin
            #1;
            check($sformatf("trap_state_%0d", c), 32'(dut.state_q), 32'(ST_ILLEGAL));
            check($sformatf("trap_ctl_%0d", c), 32'(sample_ctl()),
                  32'(exp_ctl(ST_ILLEGAL, 3'b000, 1'b0, 1'b1)));
            @(negedge clk);
        end
`else
        // Next instruction runs normally with the flag still set.
        run_instr(mk("after_ill_add", 6'b000000, 6'b100000, 1'b0, 3'b000));
        run_instr(mk("ill_funct", 6'b000000, 6'b100100, 1'b0, 3'b000));
`endif
        reset_n = 1'b0;
        @(negedge clk);
        check("ill_rst_flag", 32'(bus.illegal), 32'd0);
        check("ill_rst_state", 32'(dut.state_q), 32'(ST_FETCH));
        reset_n = 1'b1;
        model_illegal = 1'b0;
        v = mk("resume_lw", 6'b100011, 6'b000000, 1'b0, 3'b000);
        run_instr(v);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
